// File: rtl/div_ctrl.sv
// div_ctrl: operand-entry FSM that drives a restoring shift-subtract divider.
// Defining DIV_ZERO_FLAG_EN adds a divide-by-zero trap state and the err flag.
module div_ctrl #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up,
  input  logic         down,
  input  logic         ok,
  output logic [W-1:0] num,
  output logic [W-1:0] den,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic [W-1:0] leds,
  output logic [2:0]   state,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [2:0] S_NUM = 3'd0;
  localparam logic [2:0] S_DEN = 3'd1;
  localparam logic [2:0] S_RUN = 3'd2;
  localparam logic [2:0] S_QUO = 3'd3;
  localparam logic [2:0] S_REM = 3'd4;
`ifdef DIV_ZERO_FLAG_EN
  localparam logic [2:0] S_ERR = 3'd5;
`endif

  logic [2:0]    r_state;
  logic [W-1:0]  r_num;
  logic [W-1:0]  r_den;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dvd;
  logic [W:0]    r_part;
  logic [CW-1:0] r_cnt;
  logic          r_done;

  logic [W-1:0]  w_step;
  logic [W-1:0]  w_num_nx;
  logic [W-1:0]  w_den_nx;
  logic [W:0]    w_shift;
  logic [W:0]    w_diff;
  logic [W:0]    w_part_nx;
  logic          w_fits;
  logic          w_last;
  logic          w_trap;

  // Simultaneous up and down cancel out.
  always_comb begin
    w_step = '0;
    if (up && !down) begin
      w_step = W'(1);
    end else if (down && !up) begin
      w_step = '1;
    end
  end

  assign w_num_nx = r_num + w_step;
  assign w_den_nx = r_den + w_step;

  // r_dvd shifts the dividend out of its MSB while quotient bits enter at the LSB.
  assign w_shift   = (W + 1)'({r_part, r_dvd[W-1]});
  assign w_diff    = w_shift - {1'b0, r_den};
  assign w_fits    = (w_shift >= {1'b0, r_den});
  assign w_part_nx = w_fits ? w_diff : w_shift;
  assign w_last    = (r_cnt == CW'(W - 1));

`ifdef DIV_ZERO_FLAG_EN
  logic r_err;

  assign w_trap = (w_den_nx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_DEN && ok && w_trap) begin
      r_err <= 1'b1;
    end else if (r_state == S_ERR && ok) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  assign w_trap = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_NUM;
      r_num   <= '0;
      r_den   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_part  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_NUM: begin
          r_num <= w_num_nx;
          if (ok) begin
            r_state <= S_DEN;
          end
        end
        S_DEN: begin
          r_den <= w_den_nx;
          if (ok) begin
            if (w_trap) begin
              r_state <= 3'd5;
            end else begin
              r_state <= S_RUN;
              r_dvd   <= r_num;
              r_part  <= '0;
              r_cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          r_part <= w_part_nx;
          r_dvd  <= W'({r_dvd, w_fits});
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_quot  <= W'({r_dvd, w_fits});
            r_rem   <= W'(w_part_nx);
            r_done  <= 1'b1;
            r_state <= S_QUO;
          end
        end
        S_QUO: begin
          if (ok) begin
            r_state <= S_REM;
          end
        end
        S_REM: begin
          if (ok) begin
            r_state <= S_NUM;
          end
        end
`ifdef DIV_ZERO_FLAG_EN
        S_ERR: begin
          if (ok) begin
            r_state <= S_DEN;
          end
        end
`endif
        default: r_state <= S_NUM;
      endcase
    end
  end

  always_comb begin
    leds = '0;
    case (r_state)
      S_NUM:   leds = r_num;
      S_DEN:   leds = r_den;
      S_QUO:   leds = r_quot;
      S_REM:   leds = r_rem;
      default: leds = '0;
    endcase
  end

  assign num   = r_num;
  assign den   = r_den;
  assign quot  = r_quot;
  assign rem   = r_rem;
  assign state = r_state;
  assign busy  = (r_state == S_RUN);
  assign done  = r_done;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL provide parameter W, default 4: operand, quotient and remainder width in bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port up, input, 1: active-high single-cycle increment pulse, already synchronized.
REQ-005 SHALL have port down, input, 1: active-high single-cycle decrement pulse, already synchronized.
REQ-006 SHALL have port ok, input, 1: active-high single-cycle advance pulse, already synchronized.
REQ-007 SHALL have port num, output, W: current numerator register.
REQ-008 SHALL have port den, output, W: current denominator register.
REQ-009 SHALL have port quot, output, W: last computed quotient.
REQ-010 SHALL have port rem, output, W: last computed remainder.
REQ-011 SHALL have port leds, output, W: display value selected by state.
REQ-012 SHALL have port state, output, 3: FSM state encoding.
REQ-013 SHALL have port busy, output, 1: high while division iterates.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on result completion.
REQ-015 SHALL have port err, output, 1: divide-by-zero flag (see Configuration).

Function
REQ-016 FSM SHALL use states S_NUM=0, S_DEN=1, S_RUN=2, S_QUO=3, S_REM=4, S_ERR=5.
REQ-017 S_NUM: up increments num, down decrements num, both modulo 2^W; ok -> S_DEN.
REQ-018 S_DEN: up/down edit den identically; ok -> S_RUN, or -> S_ERR under REQ-030.
REQ-019 up and down asserted in the same cycle SHALL leave the operand unchanged.
REQ-020 up/down SHALL be ignored outside S_NUM and S_DEN.
REQ-021 ok together with up/down in S_NUM/S_DEN: the edit and the transition SHALL both take effect in that cycle.
REQ-022 S_RUN SHALL perform restoring shift-subtract division, one quotient bit per cycle, MSB first, for exactly W cycles, using a W+1-bit partial remainder.
REQ-023 Latency: ok accepted in S_DEN at cycle t -> busy high during cycles t+1..t+W; state=S_QUO, quot/rem valid and done=1 at cycle t+W+1.
REQ-024 ok SHALL be ignored in S_RUN; num and den SHALL remain frozen during S_RUN.
REQ-025 quot and rem SHALL hold their values until the next S_RUN completes.
REQ-026 S_QUO: ok -> S_REM. S_REM: ok -> S_NUM, with num and den retained.
REQ-027 leds SHALL equal num in S_NUM, den in S_DEN, quot in S_QUO, rem in S_REM, and 0 in S_RUN and S_ERR.
REQ-028 Unused state encodings SHALL return to S_NUM on the next clock.

Reset
REQ-029 With rst high at a clock edge: state=S_NUM; num, den, quot, rem, leds = 0; busy, done, err = 0; the iteration counter is cleared. This applies in any state, including mid-S_RUN, and takes priority over all inputs.

Configuration
REQ-030 With macro DIV_ZERO_FLAG_EN defined: ok in S_DEN with den==0 SHALL go to S_ERR with err=1 and quot/rem unchanged; ok in S_ERR SHALL clear err and return to S_DEN.
REQ-031 Without DIV_ZERO_FLAG_EN: S_ERR and err logic SHALL be absent, err is tied to 0, and den==0 SHALL run normally, yielding quot=2^W-1 and rem=num.

Verification
REQ-032 Reset; up x13, ok, up x4, ok -> busy for 4 cycles, then done pulse; quot=3, rem=1; leds=3; ok -> leds=1.
REQ-033 num=15, up -> num=0; num=0, down -> num=15; up and down together -> num unchanged.
REQ-034 den=0, ok: with DIV_ZERO_FLAG_EN -> state=5, err=1, leds=0, then ok -> state=1, err=0; without the macro -> quot=15, rem=num after 4 cycles.
REQ-035 Assert rst in the 2nd cycle of S_RUN -> next cycle state=0, busy=0, all registers 0, no done pulse.
REQ-036 ok pulses and up pulses during S_RUN -> no state skip, num/den unchanged, done still arrives at t+W+1.
